// File: rtl/change_dispenser_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispenser_ctrl
//
// Pays out change after a vend by driving the coin hopper one coin at a time.
// Greedy selection of $5/$2/$1 coins, skipping any tube flagged empty, with a
// pulse/ack handshake per coin and a bounded wait for the ack. Reports
// completion with a one-cycle done pulse, or parks in a fault state until
// fault_clr is asserted.
//
// Parameters
//   AMT_W          width of change amount and remaining count
//   PULSE_CYCLES   cycles each hop_coin* drive pulse is held high (>=1)
//   GAP_CYCLES     idle cycles between coins after ack (>=1)
//   TIMEOUT_CYCLES max cycles waiting for hop_ack before fault (>=1)
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   start        in   1-cycle request, sampled only when idle
//   change_amt   in   dollars to pay out, latched on accepted start
//   hop_empty    in   tube empty flags {$5,$2,$1}
//   hop_ack      in   hopper confirms one coin dispensed
//   fault_clr    in   clears fault, returns to idle
//   hop_coin5    out  drive pulse, $5 tube
//   hop_coin2    out  drive pulse, $2 tube
//   hop_coin1    out  drive pulse, $1 tube
//   busy         out  payout in progress (select/pulse/wait/gap/done)
//   done         out  1-cycle pulse, payout complete
//   fault        out  high while faulted
//   remaining    out  dollars still owed
//   coins_out    out  coins dispensed this transaction (saturating)
// -----------------------------------------------------------------------------
module change_dispenser_ctrl #(
   parameter int AMT_W          = 8,
   parameter int PULSE_CYCLES   = 4,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AMT_W-1:0] change_amt,
   input  logic [2:0]       hop_empty,
   input  logic             hop_ack,
   input  logic             fault_clr,
   output logic             hop_coin5,
   output logic             hop_coin2,
   output logic             hop_coin1,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] remaining,
   output logic [7:0]       coins_out
);

   // State encoding
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SELECT   = 3'd1;
   localparam logic [2:0] S_PULSE    = 3'd2;
   localparam logic [2:0] S_WAIT_ACK = 3'd3;
   localparam logic [2:0] S_GAP      = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_FAULT    = 3'd6;

   // One shared down-the-line counter serves the pulse, ack-wait and gap
   // phases; it is sized for the longest of the three.
   localparam int CNT_MAX_A = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [AMT_W-1:0] AMT_5 = AMT_W'(5);
   localparam logic [AMT_W-1:0] AMT_2 = AMT_W'(2);
   localparam logic [AMT_W-1:0] AMT_1 = AMT_W'(1);

   logic [2:0]       state,     state_nx;
   logic [CNT_W-1:0] cnt,       cnt_nx;
   logic [2:0]       denom,     denom_nx;   // one-hot {$5,$2,$1}, same order as hop_empty
   logic [AMT_W-1:0] rem_nx;
   logic [7:0]       coins_nx;
   logic [AMT_W-1:0] denom_amt;

   always_comb begin
      unique case (denom)
         3'b100:  denom_amt = AMT_5;
         3'b010:  denom_amt = AMT_2;
         default: denom_amt = AMT_1;
      endcase
   end

   // Next-state and datapath logic.
   // NOTE: every variable gets a default at the top of this block so no path
   // leaves one unassigned; that is what keeps this combinational and latch-free.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      denom_nx = denom;
      rem_nx   = remaining;
      coins_nx = coins_out;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               rem_nx   = change_amt;
               coins_nx = '0;
               state_nx = S_SELECT;
            end
         end

         S_SELECT: begin
            cnt_nx = '0;
            // Largest usable coin that does not overshoot the amount owed,
            // so remaining can never underflow.
            if (remaining == '0) begin
               state_nx = S_DONE;
            end else if (!hop_empty[2] && remaining >= AMT_5) begin
               denom_nx = 3'b100;
               state_nx = S_PULSE;
            end else if (!hop_empty[1] && remaining >= AMT_2) begin
               denom_nx = 3'b010;
               state_nx = S_PULSE;
            end else if (!hop_empty[0]) begin
               denom_nx = 3'b001;
               state_nx = S_PULSE;
            end else begin
               state_nx = S_FAULT;
            end
         end

         S_PULSE: begin
            if (cnt == PULSE_LAST) begin
               cnt_nx   = '0;
               state_nx = S_WAIT_ACK;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end

         S_WAIT_ACK: begin
            // An ack on the final allowed cycle still counts as success.
            if (hop_ack) begin
               rem_nx   = remaining - denom_amt;
               if (coins_out != 8'hFF) coins_nx = coins_out + 8'd1;
               cnt_nx   = '0;
               state_nx = S_GAP;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nx = S_FAULT;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end

         S_GAP: begin
            if (cnt == GAP_LAST) state_nx = S_SELECT;
            else                 cnt_nx   = cnt + CNT_W'(1);
         end

         S_DONE:  state_nx = S_IDLE;

         // remaining/coins_out stay frozen for diagnostics; start is ignored.
         S_FAULT: if (fault_clr) state_nx = S_IDLE;

         default: state_nx = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs. Outputs are decoded from the
   // next state so they line up exactly with the state they describe.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: the async reset clears the hopper drives immediately, so an abort
   // mid-pulse stops the motor without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         denom     <= 3'b000;
         remaining <= '0;
         coins_out <= '0;
         hop_coin5 <= 1'b0;
         hop_coin2 <= 1'b0;
         hop_coin1 <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         denom     <= denom_nx;
         remaining <= rem_nx;
         coins_out <= coins_nx;
         hop_coin5 <= (state_nx == S_PULSE) && denom_nx[2];
         hop_coin2 <= (state_nx == S_PULSE) && denom_nx[1];
         hop_coin1 <= (state_nx == S_PULSE) && denom_nx[0];
         busy      <= (state_nx == S_SELECT) || (state_nx == S_PULSE) ||
                      (state_nx == S_WAIT_ACK) || (state_nx == S_GAP) ||
                      (state_nx == S_DONE);
         done      <= (state_nx == S_DONE);
         fault     <= (state_nx == S_FAULT);
      end
   end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser_ctrl
//
// Self-checking bench for change_dispenser_ctrl. A behavioural payout model
// (plain greedy arithmetic over the amount and tube flags) predicts the coin
// sequence, the final remaining/coins_out, and whether the run ends in done
// or fault; a cycle-level hopper responder acks each coin after a chosen
// delay and records what was actually pulsed.
// -----------------------------------------------------------------------------
module tb_change_dispenser_ctrl;

   localparam int AMT_W = 8;
   localparam int P     = 4;    // pulse cycles
   localparam int G     = 4;    // gap cycles
   localparam int T     = 40;   // ack timeout cycles
   localparam int BUDGET = 3000;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [AMT_W-1:0] change_amt;
   logic [2:0]       hop_empty;
   logic             hop_ack;
   logic             fault_clr;
   logic             hop_coin5, hop_coin2, hop_coin1;
   logic             busy, done, fault;
   logic [AMT_W-1:0] remaining;
   logic [7:0]       coins_out;

   change_dispenser_ctrl #(
      .AMT_W(AMT_W), .PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .change_amt(change_amt),
      .hop_empty(hop_empty), .hop_ack(hop_ack), .fault_clr(fault_clr),
      .hop_coin5(hop_coin5), .hop_coin2(hop_coin2), .hop_coin1(hop_coin1),
      .busy(busy), .done(done), .fault(fault),
      .remaining(remaining), .coins_out(coins_out)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int coin_val(input logic [2:0] c);
      case (c)
         3'b100:  return 5;
         3'b010:  return 2;
         3'b001:  return 1;
         default: return 0;
      endcase
   endfunction

   // Reference model results
   int exp_q[$];
   int got_q[$];
   bit exp_fault;
   int exp_rem;
   int exp_coins;

   // Greedy payout: largest non-empty coin not exceeding what is owed.
   // Without acks the first coin times out and nothing is deducted.
   task automatic model(input int amt, input logic [2:0] empty, input bit ack_en);
      int rem;
      int c;
      rem = amt;
      exp_q.delete();
      exp_fault = 1'b0;
      exp_coins = 0;
      while (rem > 0) begin
         c = 0;
         if      (!empty[2] && rem >= 5) c = 5;
         else if (!empty[1] && rem >= 2) c = 2;
         else if (!empty[0])             c = 1;
         if (c == 0) begin
            exp_fault = 1'b1;
            break;
         end
         exp_q.push_back(c);
         if (!ack_en) begin
            exp_fault = 1'b1;
            break;
         end
         rem = rem - c;
         exp_coins++;
      end
      exp_rem = rem;
   endtask

   // One transaction: start, act as the hopper, then compare with the model.
   // poke_iter>0 re-asserts start mid-payout with a different amount.
   task automatic run_txn(input string name, input int amt, input logic [2:0] empty,
                          input int d, input bit ack_en, input int poke_iter);
      logic [2:0] coinv, prev;
      int  len, iter, ack_wait, proto_err, exp_iter;
      bit  term, ack_pending, seq_ok, saw_done, saw_fault;

      model(amt, empty, ack_en);

      @(negedge clk);
      start      = 1'b1;
      change_amt = AMT_W'(amt);
      hop_empty  = empty;
      hop_ack    = 1'b0;
      @(negedge clk);
      start = 1'b0;

      got_q.delete();
      prev = 3'b000; len = 0; iter = 0; ack_wait = 0; proto_err = 0;
      term = 1'b0; ack_pending = 1'b0; saw_done = 1'b0; saw_fault = 1'b0;

      while (!term && iter < BUDGET) begin
         @(negedge clk);
         iter++;
         hop_ack = 1'b0;
         start   = 1'b0;
         if (iter == poke_iter) begin
            start      = 1'b1;
            change_amt = AMT_W'(37);
         end
         coinv = {hop_coin5, hop_coin2, hop_coin1};
         if ($countones(coinv) > 1) proto_err++;
         if (coinv != 3'b000) begin
            if (coinv == prev) len++;
            else               len = 1;
         end else if (prev != 3'b000) begin
            got_q.push_back(coin_val(prev));
            if (len != P) proto_err++;
            ack_pending = 1'b1;
            ack_wait    = d;
         end
         prev = coinv;
         if (ack_pending && ack_en) begin
            if (ack_wait == 0) begin
               hop_ack     = 1'b1;
               ack_pending = 1'b0;
            end else begin
               ack_wait--;
            end
         end
         if (!fault && !busy) proto_err++;
         if (done && fault) proto_err++;
         if (done || fault) begin
            term      = 1'b1;
            saw_done  = done;
            saw_fault = fault;
         end
      end
      start   = 1'b0;
      hop_ack = 1'b0;

      check({name, "/terminated"}, 32'(term), 32'd1);
      check({name, "/fault"}, 32'(saw_fault), 32'(exp_fault));
      check({name, "/done"}, 32'(saw_done), 32'(!exp_fault));
      check({name, "/remaining"}, 32'(remaining), 32'(exp_rem));
      check({name, "/coins_out"}, 32'(coins_out), 32'(exp_coins));
      check({name, "/num_pulses"}, 32'(got_q.size()), 32'(exp_q.size()));
      seq_ok = (got_q.size() == exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] != exp_q[i]) seq_ok = 1'b0;
      check({name, "/coin_sequence"}, 32'(seq_ok), 32'd1);
      check({name, "/protocol_errs"}, 32'(proto_err), 32'd0);

      if (!ack_en && exp_q.size() > 0) exp_iter = 1 + P + T;
      else                             exp_iter = exp_coins * (P + G + d + 2) + 1;
      check({name, "/latency"}, 32'(iter), 32'(exp_iter));

      if (saw_done) begin
         @(negedge clk);
         check({name, "/done_one_cycle"}, 32'({done, busy}), 32'd0);
      end else if (saw_fault) begin
         start      = 1'b1;
         change_amt = AMT_W'(9);
         @(negedge clk);
         start = 1'b0;
         check({name, "/start_ignored_in_fault"}, 32'({fault, busy}), 32'b10);
         fault_clr = 1'b1;
         @(negedge clk);
         fault_clr = 1'b0;
         check({name, "/fault_cleared"}, 32'({fault, busy}), 32'd0);
         check({name, "/rem_kept_after_clr"}, 32'(remaining), 32'(exp_rem));
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      change_amt = '0;
      hop_empty  = 3'b000;
      hop_ack    = 1'b0;
      fault_clr  = 1'b0;

      #1;
      check("reset/outputs", 32'({hop_coin5, hop_coin2, hop_coin1, busy, done, fault}), 32'd0);
      check("reset/counts", 32'({remaining, coins_out}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset/idle_after_release", 32'({busy, done, fault}), 32'd0);

      // Directed cases
      run_txn("amt8_full",     8, 3'b000, 2, 1'b1, 0);
      run_txn("amt0",          0, 3'b000, 0, 1'b1, 0);
      run_txn("amt6_no5",      6, 3'b100, 1, 1'b1, 0);
      run_txn("amt3_only5",    3, 3'b011, 0, 1'b1, 0);
      run_txn("amt5_timeout",  5, 3'b000, 0, 1'b0, 0);
      run_txn("amt7_restart",  7, 3'b000, 3, 1'b1, 6);

      // Reset in the middle of a pulse
      @(negedge clk);
      start      = 1'b1;
      change_amt = AMT_W'(5);
      hop_empty  = 3'b000;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst/pulse_active", 32'({hop_coin5, hop_coin2, hop_coin1}), 32'b100);
      #1 rst = 1'b1;
      #1;
      check("midrst/outputs_async", 32'({hop_coin5, hop_coin2, hop_coin1, busy, done, fault}), 32'd0);
      check("midrst/counts_async", 32'({remaining, coins_out}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst/idle_after_release", 32'({busy, done, fault}), 32'd0);
      run_txn("after_rst_amt1", 1, 3'b000, 1, 1'b1, 0);

      // Randomized transactions
      for (int n = 0; n < 20; n++) begin
         int          amt, dly;
         logic [2:0]  emp;
         bit          aen;
         amt = int'($urandom_range(0, 40));
         emp = 3'($urandom_range(0, 7));
         dly = int'($urandom_range(0, 4));
         aen = ($urandom_range(0, 5) != 0);
         run_txn($sformatf("rand%0d_amt%0d_e%0b", n, amt, emp), amt, emp, dly, aen, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
